// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction fetch front-end sitting directly upstream of the unified I/D
//   cache. It presents two fetch addresses per request, pcx = fpc and
//   pcy = fpc + 4. It captures up to two hit instructions per ISSUE/CHECK pair.
//   Captured {pc, inst} pairs are buffered in a FIFO for the decoder. A jump
//   flushes the FIFO and redirects the fetch PC.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   rdy               global ready; low freezes every register
//   jump_en, jump_pc  redirect request and word-aligned target
//   en_rx, pcx        port-x request enable / address (fetch PC)
//   hitx, instx       port-x hit (registered by the cache) / instruction
//   en_ry, pcy        port-y request enable / address (fetch PC + 4)
//   hity, insty       port-y hit / instruction
//   inst_valid        FIFO head valid
//   inst_out, inst_pc FIFO head instruction / PC
//   inst_ready        decoder pop strobe
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
  parameter int          QUEUE_DEPTH = 8,
  parameter int          QPTR_WIDTH  = 3,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_en,
  input  logic [31:0] jump_pc,
  output logic        en_rx,
  output logic [31:0] pcx,
  input  logic        hitx,
  input  logic [31:0] instx,
  output logic        en_ry,
  output logic [31:0] pcy,
  input  logic        hity,
  input  logic [31:0] insty,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int             CW      = QPTR_WIDTH + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [0:0] {
    ST_ISSUE = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [31:0]           fpc_r;
  logic [31:0]           fpc_next_s;
  logic [31:0]           pcy_r;
  logic [31:0]           req_pc_r;
  logic                  en_r;
  logic                  valid_r;
  logic [QPTR_WIDTH-1:0] head_r;
  logic [QPTR_WIDTH-1:0] tail_r;
  logic [QPTR_WIDTH-1:0] tail_plus1_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_next_s;
  logic [CW-1:0]         free_s;
  logic                  push_x_s;
  logic                  push_y_s;
  logic                  pop_s;
  logic [31:0]           mem_pc_r   [QUEUE_DEPTH];
  logic [31:0]           mem_inst_r [QUEUE_DEPTH];

  // Next-state, push decision and FIFO bookkeeping.
  always_comb begin
    state_next_s = state_r;
    fpc_next_s   = fpc_r;
    push_x_s     = 1'b0;
    push_y_s     = 1'b0;
    // Room is judged on the count at cycle start, so a same-cycle pop never helps.
    free_s       = DEPTH_C - count_r;
    case (state_r)
      ST_ISSUE: begin
        state_next_s = ST_CHECK;
      end
      ST_CHECK: begin
        state_next_s = ST_ISSUE;
        if (hitx && hity && (free_s >= CW'(2'd2))) begin
          push_x_s   = 1'b1;
          push_y_s   = 1'b1;
          fpc_next_s = req_pc_r + 32'd8;
        end else if (hitx && (free_s >= CW'(1'b1))) begin
          // A lone y hit is dropped to keep program order.
          push_x_s   = 1'b1;
          fpc_next_s = req_pc_r + 32'd4;
        end else begin
          // Miss or full: keep pcx so the cache can fill and hit later.
          fpc_next_s = fpc_r;
        end
      end
      default: begin
        state_next_s = ST_ISSUE;
      end
    endcase
    pop_s        = inst_ready && (count_r != {CW{1'b0}});
    tail_plus1_s = tail_r + QPTR_WIDTH'(1'b1);
    count_next_s = count_r + CW'(push_x_s) + CW'(push_y_s) - CW'(pop_s);
  end

  // FSM state register; a jump always restarts at ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ISSUE;
    end else if (rdy) begin
      if (jump_en) begin
        state_r <= ST_ISSUE;
      end else begin
        state_r <= state_next_s;
      end
    end
  end

  // Fetch address registers and cache request enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_r    <= RESET_PC;
      pcy_r    <= RESET_PC + 32'd4;
      req_pc_r <= RESET_PC;
      en_r     <= 1'b0;
    end else if (rdy) begin
      en_r <= 1'b1;
      if (jump_en) begin
        fpc_r <= jump_pc;
        pcy_r <= jump_pc + 32'd4;
      end else begin
        fpc_r <= fpc_next_s;
        pcy_r <= fpc_next_s + 32'd4;
        if (state_r == ST_ISSUE) begin
          req_pc_r <= fpc_r;
        end
      end
    end
  end

  // FIFO pointers, occupancy and head-valid flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {QPTR_WIDTH{1'b0}};
      tail_r  <= {QPTR_WIDTH{1'b0}};
      count_r <= {CW{1'b0}};
      valid_r <= 1'b0;
    end else if (rdy) begin
      if (jump_en) begin
        head_r  <= {QPTR_WIDTH{1'b0}};
        tail_r  <= {QPTR_WIDTH{1'b0}};
        count_r <= {CW{1'b0}};
        valid_r <= 1'b0;
      end else begin
        head_r  <= head_r + QPTR_WIDTH'(pop_s);
        tail_r  <= tail_r + QPTR_WIDTH'(push_x_s) + QPTR_WIDTH'(push_y_s);
        count_r <= count_next_s;
        valid_r <= (count_next_s != {CW{1'b0}});
      end
    end
  end

  // FIFO data storage; contents are only meaningful while inst_valid is set.
  always_ff @(posedge clk) begin
    if (!rst && rdy && !jump_en) begin
      if (push_x_s) begin
        mem_pc_r[tail_r]   <= req_pc_r;
        mem_inst_r[tail_r] <= instx;
      end
      if (push_y_s) begin
        mem_pc_r[tail_plus1_s]   <= req_pc_r + 32'd4;
        mem_inst_r[tail_plus1_s] <= insty;
      end
    end
  end

  assign en_rx      = en_r;
  assign en_ry      = en_r;
  assign pcx        = fpc_r;
  assign pcy        = pcy_r;
  assign inst_valid = valid_r;
  assign inst_out   = mem_inst_r[head_r];
  assign inst_pc    = mem_pc_r[head_r];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed scenarios plus a randomized run for inst_fetch_queue. A small
//   cache model answers the fetch ports. Every popped entry is checked against
//   the expected program-order PC stream and the instruction stored at that PC.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_en, inst_ready;
  logic [31:0] jump_pc;
  logic        en_rx, en_ry, hitx, hity, inst_valid;
  logic [31:0] pcx, pcy, instx, insty, inst_out, inst_pc;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // cache model knobs
  logic        x_on, y_on, rand_hits;
  logic [31:0] y_block_pc, x_block_pc;
  int          x_block_end;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t popped[$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.QUEUE_DEPTH(8), .QPTR_WIDTH(3), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_en(jump_en), .jump_pc(jump_pc),
    .en_rx(en_rx), .pcx(pcx), .hitx(hitx), .instx(instx),
    .en_ry(en_ry), .pcy(pcy), .hity(hity), .insty(insty),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Cache: hit flags are registered one edge after the address; cleared while rdy is low.
  always @(posedge clk) begin
    if (!rdy) begin
      hitx <= 1'b0;
      hity <= 1'b0;
    end else if (rand_hits) begin
      hitx <= ($urandom_range(0, 3) != 0);
      hity <= ($urandom_range(0, 3) != 0);
    end else begin
      hitx <= x_on && !((pcx == x_block_pc) && (cyc < x_block_end));
      hity <= y_on && (pcx != y_block_pc);
    end
    instx <= inst_of(pcx);
    insty <= inst_of(pcy);
  end

  // Decoder-side monitor: records every pop that the design must perform.
  always @(negedge clk) begin
    if (!rst && rdy && !jump_en && inst_valid && inst_ready)
      popped.push_back('{inst_pc, inst_out});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [31:0] target);
    jump_en = 1'b1;
    jump_pc = target;
    tick();
    jump_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; jump_en = 1'b0; jump_pc = 32'h0; inst_ready = 1'b0;
    x_on = 1'b1; y_on = 1'b1; rand_hits = 1'b0;
    y_block_pc = 32'hFFFF_FFF0; x_block_pc = 32'hFFFF_FFF0; x_block_end = 0;
    repeat (3) tick();
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (en_rx !== 1'b0) begin n_fail++; $display("FAIL reset_en_rx: got %b expected 0", en_rx); end
    n_cmp++; if (en_ry !== 1'b0) begin n_fail++; $display("FAIL reset_en_ry: got %b expected 0", en_ry); end
    n_cmp++; if (pcx !== 32'h0) begin n_fail++; $display("FAIL reset_pcx: got %h expected 00000000", pcx); end
    n_cmp++; if (pcy !== 32'h4) begin n_fail++; $display("FAIL reset_pcy: got %h expected 00000004", pcy); end
    rst = 1'b0;
  endtask

  // Scenario 1: always hit, always pop -> one instruction per cycle after fill.
  task automatic test_stream();
    inst_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (en_rx !== 1'b1) begin n_fail++; $display("FAIL stream_en_rx: got %b expected 1", en_rx); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * i) || inst_out !== inst_of(32'(4 * i))) begin
        n_fail++;
        $display("FAIL stream_%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                 i, inst_valid, inst_pc, inst_out, 32'(4 * i), inst_of(32'(4 * i)));
      end
      tick();
    end
  endtask

  // Scenario 2: x hits, y misses -> a single entry and fetch advances by 4.
  task automatic test_x_only();
    inst_ready = 1'b0;
    y_block_pc = 32'h100;
    do_jump(32'h100);
    n_cmp++; if (inst_valid !== 1'b0 || pcx !== 32'h100) begin n_fail++; $display("FAIL xonly_jump: got v=%b pcx=%h expected v=0 pcx=00000100", inst_valid, pcx); end
    tick(); tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_out !== inst_of(32'h100)) begin n_fail++; $display("FAIL xonly_entry: got v=%b pc=%h inst=%h expected v=1 pc=00000100 inst=%h", inst_valid, inst_pc, inst_out, inst_of(32'h100)); end
    n_cmp++; if (pcx !== 32'h104 || pcy !== 32'h108) begin n_fail++; $display("FAIL xonly_pc: got pcx=%h pcy=%h expected 00000104 00000108", pcx, pcy); end
    y_block_pc = 32'hFFFF_FFF0;
  endtask

  // Scenario 3: repeated misses hold pcx; the missed PC is delivered exactly once.
  task automatic test_miss_hold();
    int base;
    inst_ready  = 1'b1;
    x_block_pc  = 32'h200;
    x_block_end = cyc + 12;
    do_jump(32'h200);
    base = popped.size();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (pcx !== 32'h200) begin n_fail++; $display("FAIL miss_hold_%0d: got pcx=%h expected 00000200", i, pcx); end
      tick();
    end
    repeat (30) tick();
    n_cmp++; if (popped.size() - base < 8) begin n_fail++; $display("FAIL miss_progress: got %0d pops expected at least 8", popped.size() - base); end
    for (int k = 0; k < 8 && base + k < popped.size(); k++) begin
      n_cmp++;
      if (popped[base + k].pc !== 32'h200 + 32'(4 * k) || popped[base + k].inst !== inst_of(32'h200 + 32'(4 * k))) begin
        n_fail++;
        $display("FAIL miss_stream_%0d: got pc=%h inst=%h expected pc=%h", k, popped[base + k].pc, popped[base + k].inst, 32'h200 + 32'(4 * k));
      end
    end
    x_block_pc = 32'hFFFF_FFF0;
  endtask

  // Scenario 4: no pops -> queue fills to 8 without overwrite; last fetch pushes only x.
  task automatic test_full();
    int base;
    inst_ready = 1'b0;
    y_block_pc = 32'h0;
    do_jump(32'h0);
    base = popped.size();
    repeat (40) tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL full_head: got v=%b pc=%h expected v=1 pc=00000000", inst_valid, inst_pc); end
    n_cmp++; if (pcx !== 32'h20 || pcy !== 32'h24) begin n_fail++; $display("FAIL full_pc: got pcx=%h pcy=%h expected 00000020 00000024", pcx, pcy); end
    inst_ready = 1'b1;
    x_on       = 1'b0;
    repeat (20) tick();
    n_cmp++; if (popped.size() - base !== 8) begin n_fail++; $display("FAIL full_count: got %0d entries expected 8", popped.size() - base); end
    for (int k = 0; k < 8 && base + k < popped.size(); k++) begin
      n_cmp++;
      if (popped[base + k].pc !== 32'(4 * k)) begin
        n_fail++;
        $display("FAIL full_entry_%0d: got pc=%h expected %h", k, popped[base + k].pc, 32'(4 * k));
      end
    end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got v=%b expected 0", inst_valid); end
    x_on       = 1'b1;
    y_block_pc = 32'hFFFF_FFF0;
  endtask

  // Scenario 5: jump on a cycle that also pushes and pops flushes everything.
  task automatic test_jump_flush();
    int base;
    inst_ready = 1'b0;
    y_block_pc = 32'h0;
    do_jump(32'h0);
    repeat (6) tick();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL flush_pre: got v=%b pc=%h expected v=1 pc=00000000", inst_valid, inst_pc); end
    jump_en    = 1'b1;
    jump_pc    = 32'h40;
    inst_ready = 1'b1;
    y_block_pc = 32'hFFFF_FFF0;
    tick();
    jump_en = 1'b0;
    base    = popped.size();
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (pcx !== 32'h40 || pcy !== 32'h44) begin n_fail++; $display("FAIL flush_pc: got pcx=%h pcy=%h expected 00000040 00000044", pcx, pcy); end
    repeat (20) tick();
    n_cmp++; if (popped.size() - base < 6) begin n_fail++; $display("FAIL flush_progress: got %0d pops expected at least 6", popped.size() - base); end
    for (int k = 0; k < 6 && base + k < popped.size(); k++) begin
      n_cmp++;
      if (popped[base + k].pc !== 32'h40 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL flush_stream_%0d: got pc=%h expected %h", k, popped[base + k].pc, 32'h40 + 32'(4 * k));
      end
    end
  endtask

  // Scenario 6: rdy low for 3 cycles in CHECK freezes everything, including pops and jumps.
  task automatic test_rdy_hold();
    int base;
    inst_ready = 1'b0;
    do_jump(32'h300);
    repeat (3) tick();
    rdy        = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h300 || pcx !== 32'h308) begin
        n_fail++;
        $display("FAIL rdy_hold_%0d: got v=%b pc=%h pcx=%h expected v=1 pc=00000300 pcx=00000308", i, inst_valid, inst_pc, pcx);
      end
      jump_en = (i == 0);
      jump_pc = 32'h500;
    end
    jump_en = 1'b0;
    rdy     = 1'b1;
    base    = popped.size();
    repeat (20) tick();
    n_cmp++; if (popped.size() - base < 6) begin n_fail++; $display("FAIL rdy_progress: got %0d pops expected at least 6", popped.size() - base); end
    for (int k = 0; k < 6 && base + k < popped.size(); k++) begin
      n_cmp++;
      if (popped[base + k].pc !== 32'h300 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL rdy_stream_%0d: got pc=%h expected %h", k, popped[base + k].pc, 32'h300 + 32'(4 * k));
      end
    end
  endtask

  // Random hits, pops, stalls and jumps against the program-order stream model.
  task automatic test_random();
    int          idx, idx0;
    logic [31:0] exp_pc, tgt;
    logic        jumped;
    rand_hits = 1'b1;
    do_jump(32'h1000);
    exp_pc = 32'h1000;
    idx    = popped.size();
    idx0   = idx;
    for (int c = 0; c < 1500; c++) begin
      inst_ready = ($urandom_range(0, 1) == 1);
      rdy        = ($urandom_range(0, 15) != 0);
      jump_en    = ($urandom_range(0, 40) == 0);
      tgt        = $urandom() & 32'hFFFF_FFFC;
      jump_pc    = tgt;
      jumped     = jump_en && rdy;
      tick();
      while (idx < popped.size()) begin
        n_cmp++;
        if (popped[idx].pc !== exp_pc || popped[idx].inst !== inst_of(exp_pc)) begin
          n_fail++;
          $display("FAIL rand_stream: got pc=%h inst=%h expected pc=%h inst=%h", popped[idx].pc, popped[idx].inst, exp_pc, inst_of(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        idx++;
      end
      if (jumped) exp_pc = tgt;
      n_cmp++;
      if (pcy !== pcx + 32'd4) begin
        n_fail++;
        $display("FAIL rand_pcy: got pcy=%h expected %h", pcy, pcx + 32'd4);
      end
    end
    n_cmp++; if (idx - idx0 <= 100) begin n_fail++; $display("FAIL rand_progress: got %0d pops expected more than 100", idx - idx0); end
    rdy       = 1'b1;
    jump_en   = 1'b0;
    rand_hits = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_x_only();
    test_miss_hold();
    test_full();
    test_jump_flush();
    test_rdy_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
